// File: rtl/branch_seq.sv
// Control-step sequencer for the Mini SRC conditional branch (T3..T6).
// Drives CON FF evaluation, latches the branch decision and conditionally loads PC.
module branch_seq #(
   parameter logic [4:0] OPC_BR = 5'b10010,
   parameter int         CNT_W  = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [31:0]      ir,
   input  logic             hold,
   input  logic             branch,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             Gra,
   output logic             Rout,
   output logic             CONin,
   output logic             PCout,
   output logic             Yin,
   output logic             Cout,
   output logic             alu_add,
   output logic             Zin,
   output logic             Zlowout,
   output logic             PCin,
   output logic             taken,
   output logic [CNT_W-1:0] taken_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T3   = 3'd1,
      S_T4   = 3'd2,
      S_T5   = 3'd3,
      S_T6   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic               taken_q, taken_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q;
   logic               is_br;
   logic               bad_start;
   logic               unused_ir;

   // Only the opcode is decoded here; the condition field goes straight to the CON FF.
   assign is_br     = (ir[31:27] == OPC_BR);
   assign unused_ir = ^ir[26:0];
   assign bad_start = (state_q == S_IDLE) && start && !is_br;

   always_comb begin
      state_d = state_q;
      taken_d = taken_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: if (start && is_br) state_d = S_T3;
         S_T3:   if (!hold) state_d = S_T4;
         S_T4: begin
            if (!hold) begin
               state_d = S_T5;
               taken_d = branch;
            end
         end
         S_T5:   if (!hold) state_d = S_T6;
         S_T6: begin
            if (!hold) begin
               state_d = S_IDLE;
               if (taken_q) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clear) begin
         state_d = S_IDLE;
         taken_d = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_IDLE;
         taken_q <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         taken_q <= taken_d;
         cnt_q   <= cnt_d;
         err_q   <= bad_start;
      end
   end

   // Strobes are registered from the next state, so they line up with state_q
   // and a clear forces them low from the following cycle.
   always_ff @(posedge clock) begin
      busy    <= (state_d != S_IDLE);
      Gra     <= (state_d == S_T3);
      Rout    <= (state_d == S_T3);
      CONin   <= (state_d == S_T3);
      PCout   <= (state_d == S_T4);
      Yin     <= (state_d == S_T4);
      Cout    <= (state_d == S_T5);
      alu_add <= (state_d == S_T5);
      Zin     <= (state_d == S_T5);
      done    <= (state_d == S_T6);
      Zlowout <= (state_d == S_T6) && taken_d;
      PCin    <= (state_d == S_T6) && taken_d;
   end

   assign err         = err_q;
   assign taken       = taken_q;
   assign taken_count = cnt_q;

endmodule

// File: tb/tb_branch_seq.sv
// Randomized self-checking bench for branch_seq against a step-level model.
module tb_branch_seq;

   localparam int         CW  = 4;
   localparam logic [4:0] OPC = 5'b10010;

   logic          clock = 1'b0;
   logic          clear, start, hold, branch;
   logic [31:0]   ir;
   logic          busy, done, err, Gra, Rout, CONin, PCout, Yin;
   logic          Cout, alu_add, Zin, Zlowout, PCin, taken;
   logic [CW-1:0] taken_count;

   int tests = 0;
   int fails = 0;

   // Model: which control step (0 = idle, 3..6 = T3..T6) the instruction is in.
   int            m_step = 0;
   logic          m_taken = 1'b0;
   int            m_count = 0;
   logic          m_err = 1'b0;

   branch_seq #(.OPC_BR(OPC), .CNT_W(CW)) dut (
      .clock(clock), .clear(clear), .start(start), .ir(ir), .hold(hold),
      .branch(branch), .busy(busy), .done(done), .err(err), .Gra(Gra),
      .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin), .Cout(Cout),
      .alu_add(alu_add), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
      .taken(taken), .taken_count(taken_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      if (clear) begin
         m_step = 0; m_taken = 1'b0; m_count = 0; m_err = 1'b0;
      end else begin
         m_err = (m_step == 0) && start && (ir[31:27] != OPC);
         if (m_step == 0) begin
            if (start && ir[31:27] == OPC) m_step = 3;
         end else if (!hold) begin
            if (m_step == 4) m_taken = branch;
            if (m_step == 6) begin
               if (m_taken) m_count = (m_count + 1) % (1 << CW);
               m_step = 0;
            end else begin
               m_step = m_step + 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [13:0] act, exp;
      logic s3, s4, s5, s6;
      s3 = (m_step == 3); s4 = (m_step == 4); s5 = (m_step == 5); s6 = (m_step == 6);
      act = {busy, done, err, Gra, Rout, CONin, PCout, Yin, Cout, alu_add, Zin,
             Zlowout, PCin, taken};
      exp = {m_step != 0, s6, m_err, s3, s3, s3, s4, s4, s5, s5, s5,
             s6 && m_taken, s6 && m_taken, m_taken};
      chk("outputs", 32'(act), 32'(exp));
      chk("taken_count", 32'(taken_count), 32'(m_count));
   endtask

   task automatic tick();
      @(posedge clock);
      model_update();
      @(negedge clock);
      compare_all();
   endtask

   task automatic issue(input logic [31:0] instr);
      start = 1'b1; ir = instr;
      tick();
      start = 1'b0;
   endtask

   initial begin
      clear = 1'b1; start = 1'b1; hold = 1'b0; branch = 1'b0; ir = 32'h9000_0005;

      // Reset with start asserted
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ctrl", 32'({done, err, Gra, CONin, PCout, Zin, PCin}), 0);
      chk("rst_count", 32'(taken_count), 0);
      clear = 1'b0; start = 1'b0;
      tick();

      // Taken branch: strobes in order, PC loaded in T6
      branch = 1'b1;
      issue(32'h9000_0005);
      chk("t3_strobes", 32'({Gra, Rout, CONin, busy}), 32'hF);
      tick();
      chk("t4_strobes", 32'({PCout, Yin, Gra}), 32'h6);
      tick();
      chk("t5_strobes", 32'({Cout, alu_add, Zin}), 32'h7);
      tick();
      chk("t6_taken", 32'({done, Zlowout, PCin}), 32'h7);
      tick();
      chk("taken_cnt1", 32'(taken_count), 1);
      chk("idle_busy", 32'(busy), 0);

      // Not taken
      branch = 1'b1;
      issue(32'h9000_0005);
      branch = 1'b0;
      tick(); tick(); tick();
      chk("t6_nottaken", 32'({done, PCin, Zlowout}), 32'h4);
      tick();
      chk("nottaken_cnt", 32'(taken_count), 1);

      // Illegal opcode
      issue(32'h1800_0000);
      chk("err_pulse", 32'({err, busy}), 32'h2);
      tick();
      chk("err_end", 32'(err), 0);

      // Stall 3 cycles in T5
      branch = 1'b1;
      issue(32'h9000_0005);
      tick(); tick();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_zin", 32'({Zin, done}), 32'h2);
      end
      hold = 1'b0;
      tick();
      chk("stall_done", 32'(done), 1);
      tick();
      chk("stall_cnt", 32'(taken_count), 2);

      // Drive count to 2^CW-1, then wrap
      for (int k = 0; k < (1 << CW) - 3; k++) begin
         issue(32'h9000_0005);
         repeat (4) tick();
      end
      chk("cnt_max", 32'(taken_count), (1 << CW) - 1);
      issue(32'h9000_0005);
      repeat (4) tick();
      chk("cnt_wrap", 32'(taken_count), 0);

      // Abort in T5
      issue(32'h9000_0005);
      tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("abort", 32'({busy, done, PCin}), 0);
      tick();
      chk("abort_idle", 32'({busy, done, PCin}), 0);
      chk("abort_cnt", 32'(taken_count), 0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         start  = ($urandom_range(0, 9) < 3);
         hold   = ($urandom_range(0, 9) < 2);
         branch = $urandom_range(0, 1);
         clear  = ($urandom_range(0, 99) < 2);
         ir     = $urandom;
         if ($urandom_range(0, 1) == 1) ir[31:27] = OPC;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_seq.md
# branch_seq

Control-step sequencer for the conditional branch instruction (brzr/brnz/brpl/brmi) in the Mini SRC datapath. It drives the CON FF from the producer side: it pulses `CONin` while register Ra is on the bus, samples the resulting `branch` flag, and then conditionally loads PC with PC+C. It sits beside the main control unit, which hands off branch-opcode instructions after fetch (T0–T2) and waits for `done`.

## Interface
Parameters:
- `OPC_BR`, 5'b10010, opcode of the branch instruction (IR[31:27])
- `CNT_W`, 16, width of the taken-branch counter

Ports:
- `clock` in 1, single clock; all state changes on rising edge
- `clear` in 1, reset, synchronous and active-high
- `start` in 1, one-cycle request from the control unit; IR valid and fetched
- `ir` in 32, instruction register; held stable by the control unit while `busy`
- `hold` in 1, freezes the FSM in its current step (memory/bus stall)
- `branch` in 1, CON FF output
- `busy` out 1, high in every non-IDLE state
- `done` out 1, one-cycle pulse in the final step
- `err` out 1, one-cycle pulse when `start` is seen with a non-branch opcode
- `Gra`, `Rout`, `CONin` out 1 each, T3 controls
- `PCout`, `Yin` out 1 each, T4 controls
- `Cout`, `alu_add`, `Zin` out 1 each, T5 controls
- `Zlowout`, `PCin` out 1 each, T6 controls (branch taken only)
- `taken` out 1, registered branch decision for the current instruction
- `taken_count` out CNT_W, number of completed taken branches

## Operation
- States: IDLE, T3, T4, T5, T6. Moore decode: control outputs depend only on state (and `taken` for T6).
- IDLE: if `start`=1 and `ir[31:27]`==OPC_BR, go to T3. If `start`=1 with any other opcode, pulse `err` next cycle and stay in IDLE. If `start`=0, stay in IDLE.
- T3: `Gra`=`Rout`=`CONin`=1. CON FF evaluates Ra against IR[20:19].
- T4: `PCout`=`Yin`=1. On the edge leaving T4, `taken` <= `branch`.
- T5: `Cout`=`alu_add`=`Zin`=1 (Z = PC + sign-extended C).
- T6: `Zlowout`=`PCin`=`taken`; `done`=1. If `taken`=1, `taken_count` increments on the edge leaving T6. Next state is IDLE.
- `hold`=1 in T3–T6: state, `taken`, and counter frozen; the current step's outputs remain asserted; `done` is not re-pulsed until the step advances. `hold` is ignored in IDLE.
- `start` while `busy` is ignored; no `err`.
- `taken_count` wraps from 2^CNT_W−1 to 0.
- The condition field is not decoded here; the CON FF reads IR directly.

## Timing
- Reset (`clear`=1 at an edge): state=IDLE; `taken`=0; `taken_count`=0; `err`=0. All control outputs, `busy`, and `done` are 0 from the following cycle. `clear` overrides `start` and `hold`.
- Reset mid-instruction: abort with no `PCin`, no `done`, and no count update.
- Latency with no hold: `start` at edge N, giving T3 in cycle N+1, T4 in N+2, T5 in N+3, and T6/`done` in N+4. `busy` is high in cycles N+1 to N+4.
- Back-to-back: `start` in the T6 cycle is ignored. A new `start` is accepted in IDLE only, so the minimum spacing is 5 cycles.
- `branch` must be settled by the end of T4 (one full cycle after the `CONin` edge).
- `err` appears the cycle after the bad `start` and lasts 1 cycle.

## Test plan
- Reset: assert `clear` 2 cycles with `start`=1 -> all outputs 0, state IDLE, `taken_count`=0.
- Taken: ir=0x9000_0005 (br, IR[20:19]=00), `branch`=1 by T4 -> T3/T4/T5 strobes in order; in T6 `PCin`=`Zlowout`=1 and `done`=1; `taken_count`=1.
- Not taken: same ir, `branch`=0 -> T6 has `PCin`=0, `done`=1, `taken_count` unchanged.
- Illegal opcode: `start` with ir=0x1800_0000 -> `err` pulse 1 cycle, `busy` stays 0.
- Stall: `hold`=1 for 3 cycles during T5 -> `Zin` held 3 extra cycles; `done` arrives 3 cycles late; a single count increment.
- Wrap/abort: preload via 2^CNT_W−1 taken branches, then one more -> `taken_count`=0. Assert `clear` in T5 -> no `PCin`, no `done`.
